// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: Tuse/Tnew register scoreboard with mult/div busy tracking for a 5-stage pipeline
module scoreboard_hazard_unit #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int CW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int MDW      = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic          d_rs_use,
    input  logic          d_rt_use,
    input  logic [1:0]    d_rs_tuse,
    input  logic [1:0]    d_rt_tuse,
    input  logic [AW-1:0] d_dst,
    input  logic          d_dst_we,
    input  logic [CW-1:0] d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    fwd_rs_d,
    output logic [1:0]    fwd_rt_d,
    output logic [1:0]    fwd_rs_e,
    output logic [1:0]    fwd_rt_e,
    output logic          md_busy
);
    logic [NREG-1:0] pend_q, pend_d;
    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic [1:0]      age_q [NREG];
    logic [1:0]      age_d [NREG];
    logic [MDW-1:0]  md_q, md_d;
    logic            e_md_q;
    logic [AW-1:0]   e_rs_q, e_rt_q;
    logic            e_rs_use_q, e_rt_use_q, e_rs_nz_q, e_rt_nz_q;
    logic            rs_haz, rt_haz, issue, md_load;

    assign md_busy  = md_q != '0;
    assign rs_haz   = d_rs_use && d_rs != '0 && pend_q[d_rs] && 32'(cnt_q[d_rs]) > 32'(d_rs_tuse);
    assign rt_haz   = d_rt_use && d_rt != '0 && pend_q[d_rt] && 32'(cnt_q[d_rt]) > 32'(d_rt_tuse);
    assign stall    = d_valid && (rs_haz || rt_haz || (d_md_use && (md_busy || e_md_q)));
    assign issue    = d_valid && !stall && !flush;
    assign md_load  = issue && d_md_start;
    assign fwd_rs_d = (d_rs != '0 && pend_q[d_rs] && cnt_q[d_rs] == '0) ? age_q[d_rs] : 2'd0;
    assign fwd_rt_d = (d_rt != '0 && pend_q[d_rt] && cnt_q[d_rt] == '0) ? age_q[d_rt] : 2'd0;
    assign fwd_rs_e = (e_rs_use_q && e_rs_nz_q && e_rs_q != '0 && pend_q[e_rs_q] && age_q[e_rs_q][1]) ? age_q[e_rs_q] : 2'd0;
    assign fwd_rt_e = (e_rt_use_q && e_rt_nz_q && e_rt_q != '0 && pend_q[e_rt_q] && age_q[e_rt_q][1]) ? age_q[e_rt_q] : 2'd0;
    assign md_d     = md_load ? (d_md_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT)) :
                      (flush && e_md_q) ? '0 : md_busy ? md_q - 1'b1 : '0;

    // Age every entry, retire W-stage entries, kill E/M entries on flush, then let a new producer overwrite
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = pend_q[r] && age_q[r] != 2'd3 && !(flush && (age_q[r] == 2'd1 || age_q[r] == 2'd2));
            cnt_d[r]  = (pend_d[r] && cnt_q[r] != '0) ? cnt_q[r] - 1'b1 : '0;
            age_d[r]  = pend_d[r] ? age_q[r] + 2'd1 : 2'd0;
            if (issue && d_dst_we && d_dst != '0 && d_dst == AW'(r)) begin
                pend_d[r] = 1'b1;
                cnt_d[r]  = d_tnew;
                age_d[r]  = 2'd1;
            end
        end
    end

    // Scoreboard state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
                age_q[r] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
                age_q[r] <= age_d[r];
            end
        end
    end

    // Mult/div busy counter and the md-instruction-in-E marker used by flush recovery
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_q   <= '0;
            e_md_q <= 1'b0;
        end else begin
            md_q   <= md_d;
            e_md_q <= md_load;
        end
    end

    // E-stage copy of the consumer's sources; stall or flush leaves a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_rs_q     <= '0;
            e_rt_q     <= '0;
            e_rs_use_q <= 1'b0;
            e_rt_use_q <= 1'b0;
            e_rs_nz_q  <= 1'b0;
            e_rt_nz_q  <= 1'b0;
        end else begin
            e_rs_q     <= issue ? d_rs : '0;
            e_rt_q     <= issue ? d_rt : '0;
            e_rs_use_q <= issue && d_rs_use;
            e_rt_use_q <= issue && d_rt_use;
            e_rs_nz_q  <= issue && pend_q[d_rs] && cnt_q[d_rs] != '0;
            e_rt_nz_q  <= issue && pend_q[d_rt] && cnt_q[d_rt] != '0;
        end
    end
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb_scoreboard_hazard_unit: directed and random checks against an instruction-history reference model
module tb_scoreboard_hazard_unit;
    logic       clk = 1'b0, reset = 1'b0, d_valid = 1'b0;
    logic [4:0] d_rs = '0, d_rt = '0, d_dst = '0;
    logic       d_rs_use = 1'b0, d_rt_use = 1'b0, d_dst_we = 1'b0;
    logic [1:0] d_rs_tuse = '0, d_rt_tuse = '0, d_tnew = '0;
    logic       d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0, flush = 1'b0;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    always #5 clk = ~clk;

    scoreboard_hazard_unit dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_use(d_rs_use), .d_rt_use(d_rt_use), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_dst(d_dst), .d_dst_we(d_dst_we), .d_tnew(d_tnew), .d_md_start(d_md_start),
        .d_md_div(d_md_div), .d_md_use(d_md_use), .flush(flush), .stall(stall),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
        .md_busy(md_busy)
    );

    typedef struct {
        bit rstn, valid, rsu, rtu, we, mds, mdd, mdu, flush;
        int rs, rt, rst, rtt, dst, tnew;
    } stim_t;
    typedef struct {bit stall; int frd, ftd, fre, fte; bit busy;} exp_t;
    typedef struct {int cyc; int dst; int tnew; bit killed;} prod_t;

    exp_t  exp_q[$];
    prod_t plog[$];
    int    now, md_cyc, md_lat, e_rs, e_rt;
    bit    md_killed, e_rsf, e_rtf, last_stall;
    int    n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
        end
    endtask

    task automatic model_reset();
        plog.delete();
        md_cyc = -100; md_lat = 0; md_killed = 0;
        e_rs = 0; e_rt = 0; e_rsf = 0; e_rtf = 0;
    endtask

    // Youngest writer of r decides: it is pending for the three cycles after issue unless flushed
    function automatic void look(input int r, output bit p, output int c, output int a);
        bit found = 0;
        p = 0; c = 0; a = 0;
        for (int i = plog.size() - 1; i >= 0; i--)
            if (!found && r != 0 && plog[i].dst == r) begin
                found = 1;
                if (!plog[i].killed && now - plog[i].cyc >= 1 && now - plog[i].cyc <= 3) begin
                    p = 1;
                    a = now - plog[i].cyc;
                    c = plog[i].tnew - (a - 1);
                    if (c < 0) c = 0;
                end
            end
    endfunction

    function automatic stim_t idle();
        stim_t s = '{default: 0};
        s.rstn = 1;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit prs, prt, pe, busy, iss;
        int crs, crt, ce, ars, art, ae;
        @(posedge clk);
        #1;
        reset = s.rstn; d_valid = s.valid; d_rs = 5'(s.rs); d_rt = 5'(s.rt);
        d_rs_use = s.rsu; d_rt_use = s.rtu; d_rs_tuse = 2'(s.rst); d_rt_tuse = 2'(s.rtt);
        d_dst = 5'(s.dst); d_dst_we = s.we; d_tnew = 2'(s.tnew);
        d_md_start = s.mds; d_md_div = s.mdd; d_md_use = s.mdu; flush = s.flush;
        if (!s.rstn) model_reset();
        look(s.rs, prs, crs, ars);
        look(s.rt, prt, crt, art);
        busy = !md_killed && now - md_cyc >= 1 && now - md_cyc <= md_lat;
        e.stall = s.valid && ((s.rsu && prs && crs > s.rst) || (s.rtu && prt && crt > s.rtt) ||
                              (s.mdu && (busy || md_cyc == now - 1)));
        e.frd = (prs && crs == 0) ? ars : 0;
        e.ftd = (prt && crt == 0) ? art : 0;
        look(e_rs, pe, ce, ae);
        e.fre = (e_rsf && pe && ae >= 2) ? ae : 0;
        look(e_rt, pe, ce, ae);
        e.fte = (e_rtf && pe && ae >= 2) ? ae : 0;
        e.busy = busy;
        exp_q.push_back(e);
        last_stall = e.stall;
        if (s.rstn) begin
            iss = s.valid && !e.stall && !s.flush;
            if (s.flush) begin
                foreach (plog[i]) if (now - plog[i].cyc == 1 || now - plog[i].cyc == 2) plog[i].killed = 1;
                if (md_cyc == now - 1) md_killed = 1;
            end
            e_rs = s.rs; e_rt = s.rt;
            e_rsf = iss && s.rsu && prs && crs > 0;
            e_rtf = iss && s.rtu && prt && crt > 0;
            if (iss && s.we && s.dst != 0) plog.push_back('{cyc: now, dst: s.dst, tnew: s.tnew, killed: 0});
            if (iss && s.mds) begin
                md_cyc = now; md_lat = s.mdd ? 10 : 5; md_killed = 0;
            end
            now++;
            while (plog.size() > 0 && now - plog[0].cyc > 4) void'(plog.pop_front());
        end
    endtask

    // Monitor: every cycle's outputs are compared against the queued prediction
    always @(negedge clk) begin : mon
        exp_t x;
        while (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("stall", int'(stall), int'(x.stall));
            chk("fwd_rs_d", int'(fwd_rs_d), x.frd);
            chk("fwd_rt_d", int'(fwd_rt_d), x.ftd);
            chk("fwd_rs_e", int'(fwd_rs_e), x.fre);
            chk("fwd_rt_e", int'(fwd_rt_e), x.fte);
            chk("md_busy", int'(md_busy), int'(x.busy));
        end
    end

    initial begin
        stim_t s, cur;
        now = 0;
        model_reset();
        s = idle(); s.rstn = 0;
        repeat (2) step(s);
        @(negedge clk); #1;
        chk("reset stall", int'(stall), 0);
        chk("reset md_busy", int'(md_busy), 0);
        step(idle());
        // lw $8 then beq $8
        s = idle(); s.valid = 1; s.dst = 8; s.we = 1; s.tnew = 2; step(s);
        s = idle(); s.valid = 1; s.rs = 8; s.rsu = 1; s.rst = 0;
        step(s); @(negedge clk); #1; chk("lw-beq stall c1", int'(stall), 1);
        step(s); @(negedge clk); #1; chk("lw-beq stall c2", int'(stall), 1);
        step(s); @(negedge clk); #1; chk("lw-beq stall c3", int'(stall), 0);
        chk("lw-beq fwd_rs_d", int'(fwd_rs_d), 3);
        // addu $10 then addu reading $10 in E
        s = idle(); s.valid = 1; s.dst = 10; s.we = 1; s.tnew = 1; step(s);
        s = idle(); s.valid = 1; s.rs = 10; s.rsu = 1; s.rst = 1; s.dst = 11; s.we = 1; s.tnew = 1;
        step(s); @(negedge clk); #1; chk("addu stall", int'(stall), 0);
        step(idle()); @(negedge clk); #1; chk("addu fwd_rs_e", int'(fwd_rs_e), 2);
        // ori $9 then jr $9
        s = idle(); s.valid = 1; s.dst = 9; s.we = 1; s.tnew = 1; step(s);
        s = idle(); s.valid = 1; s.rs = 9; s.rsu = 1;
        step(s); @(negedge clk); #1; chk("jr stall c1", int'(stall), 1);
        step(s); @(negedge clk); #1; chk("jr stall c2", int'(stall), 0);
        chk("jr fwd_rs_d", int'(fwd_rs_d), 2);
        // $0 is never tracked
        s = idle(); s.valid = 1; s.dst = 0; s.we = 1; s.tnew = 2; step(s);
        s = idle(); s.valid = 1; s.rsu = 1; s.rtu = 1;
        step(s); @(negedge clk); #1;
        chk("r0 stall", int'(stall), 0);
        chk("r0 fwd_rs_d", int'(fwd_rs_d), 0);
        chk("r0 fwd_rt_d", int'(fwd_rt_d), 0);
        step(idle()); @(negedge clk); #1; chk("r0 fwd_rs_e", int'(fwd_rs_e), 0);
        // div then mflo
        s = idle(); s.valid = 1; s.mds = 1; s.mdd = 1; s.mdu = 1; step(s);
        s = idle(); s.valid = 1; s.mdu = 1;
        for (int k = 0; k <= 10; k++) begin
            step(s); @(negedge clk); #1;
            chk($sformatf("mflo stall k=%0d", k), int'(stall), int'(k < 10));
            chk($sformatf("mflo md_busy k=%0d", k), int'(md_busy), int'(k < 10));
        end
        // lw $12 flushed in E, dependent sees RF
        s = idle(); s.valid = 1; s.dst = 12; s.we = 1; s.tnew = 2; step(s);
        s = idle(); s.flush = 1; step(s);
        s = idle(); s.valid = 1; s.rs = 12; s.rsu = 1;
        step(s); @(negedge clk); #1;
        chk("flush stall", int'(stall), 0);
        chk("flush fwd_rs_d", int'(fwd_rs_d), 0);
        // reset in the middle of a divide
        s = idle(); s.valid = 1; s.mds = 1; s.mdd = 1; s.mdu = 1; step(s);
        repeat (3) step(idle());
        @(negedge clk); #1; chk("div busy before reset", int'(md_busy), 1);
        s = idle(); s.rstn = 0; step(s);
        #1; chk("reset mid-div md_busy", int'(md_busy), 0);
        step(s);
        step(idle());
        // random traffic; a stalled instruction is held in D
        cur = idle();
        for (int n = 0; n < 3000; n++) begin
            if (!(last_stall && cur.valid)) begin
                cur = idle();
                cur.valid = $urandom_range(0, 9) < 8;
                cur.rs = $urandom_range(0, 7); cur.rt = $urandom_range(0, 7);
                cur.rsu = $urandom_range(0, 1); cur.rtu = $urandom_range(0, 1);
                cur.rst = $urandom_range(0, 2); cur.rtt = $urandom_range(0, 2);
                cur.dst = $urandom_range(0, 7); cur.we = $urandom_range(0, 3) != 0;
                cur.tnew = $urandom_range(0, 3);
                cur.mds = $urandom_range(0, 19) == 0; cur.mdd = $urandom_range(0, 1);
                cur.mdu = cur.mds || $urandom_range(0, 9) == 0;
            end
            cur.flush = $urandom_range(0, 19) == 0;
            step(cur);
        end
        repeat (2) step(idle());
        @(negedge clk); #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/scoreboard_hazard_unit.md
Name: scoreboard_hazard_unit

Overview:
- Parametrised successor to the combinational opcode-matching hazard/forward decoder of the 5-stage MIPS pipeline (F/D/E/M/W).
- Replaces the per-opcode match tables with a Tuse/Tnew register scoreboard. Each architectural register has a pending flag, a countdown and a stage-age field.
- Adds a multi-cycle mult/div busy counter with configurable latencies.
- Generates stall, D-stage and E-stage forward selects, and flush recovery.

Parameters:
- NREG, 32, number of architectural registers tracked; register 0 is never tracked.
- AW, 5, register index width (log2 NREG).
- CW, 2, Tnew countdown width.
- MULT_LAT, 5, mult/multu busy cycles.
- DIV_LAT, 10, div/divu busy cycles.
- MDW, 4, md counter width; must hold DIV_LAT.

Ports:
- clk in 1: clock.
- reset in 1: asynchronous, active-low reset.
- d_valid in 1: D holds a real instruction.
- d_rs in AW: D source 1 index.
- d_rt in AW: D source 2 index.
- d_rs_use in 1: rs is read.
- d_rt_use in 1: rt is read.
- d_rs_tuse in 2: cycles after D until rs is needed (0=D, 1=E, 2=M).
- d_rt_tuse in 2: same, for rt.
- d_dst in AW: destination register.
- d_dst_we in 1: instruction writes d_dst.
- d_tnew in CW: cycles after leaving D until the result is forwardable.
- d_md_start in 1: mult/div instruction.
- d_md_div in 1: 1=div/divu, 0=mult/multu.
- d_md_use in 1: mf/mt hi/lo, mult or div.
- flush in 1: kill the instructions currently in E and M (exception/eret).
- stall out 1: freeze PC and D; clear E.
- fwd_rs_d out 2: D select for rs: 0=RF, 1=E, 2=M, 3=W.
- fwd_rt_d out 2: D select for rt, same encoding.
- fwd_rs_e out 2: E select for rs: 0=pipe reg, 2=M, 3=W.
- fwd_rt_e out 2: E select for rt, same encoding.
- md_busy out 1: md counter nonzero.

Behaviour:
- Per-register state: pend[r], cnt[r] (CW bits), age[r] (2 bits; 1=E, 2=M, 3=W).
- Reset: all pend, cnt and age = 0; E-copy registers = 0; md counter = 0. All outputs are therefore 0 after reset.
- Issue condition: d_valid & !stall.
- On issue with d_dst_we & d_dst!=0: pend<=1, cnt<=d_tnew, age<=1. This overwrites any older entry for the same register (youngest producer wins on WAW).
- Every other pending entry ages each cycle:
  - cnt decrements, saturating at 0.
  - age increments.
  - An entry with age==3 is cleared next cycle. The RF is write-through, so D reads RF afterwards.
- Stall is combinational on the current state. It asserts when d_valid and any of the following holds:
  - d_rs_use & rs!=0 & pend[rs] & cnt[rs] > d_rs_tuse.
  - The same test for rt.
  - d_md_use & (md_busy | md instruction in E).
- While stalled: no issue occurs, the scoreboard keeps aging, and a bubble is inserted into E.
- fwd_*_d = age of the pending entry when pend & cnt==0 & index!=0; otherwise 0.
  - fwd_*_d is meaningful only when stall=0.
  - For tuse>0 with cnt>0, the consumer is re-resolved in E.
- E copies: on issue, the block latches rs, rt, use flags and whether cnt was nonzero. On stall or flush the E copy becomes a bubble.
- fwd_*_e = age of the producer entry when pend and age is 2 or 3; otherwise 0.
- md counter:
  - Loaded with MULT_LAT or DIV_LAT on an issuing d_md_start.
  - Decrements to 0.
  - md_busy = counter!=0.
- flush:
  - Clears entries with age 1 or 2 and their E copies.
  - Clears the md counter if it was loaded the previous cycle (md instruction still in E).
  - Entries with age 3 are unaffected.
- Simultaneous flush and issue: flush wins; the issue is discarded. The datapath deasserts d_valid on flush anyway.
- reset mid-operation: immediate asynchronous clear of all state.

Test Plan:
- lw $8 (tnew=2), then beq using $8 (tuse=0) -> stall=1 for 2 cycles; third cycle stall=0, fwd_rs_d=3.
- addu $8 (tnew=1), then addu reading $8 (tuse=1) -> no stall. Next cycle fwd_rs_e=2 (M).
- ori $9 (tnew=1), then jr $9 (tuse=0) -> 1 stall cycle, then fwd_rs_d=2.
- Write $0, then read $0 -> never stall; all fwd codes=0.
- div (DIV_LAT=10), then mflo -> stall held for 10 cycles; md_busy falls, then the issue proceeds.
- lw $8 issued, then flush next cycle -> pend[8]=0; a dependent instruction issues with stall=0, fwd_rs_d=0. Assert reset mid-div -> md_busy=0 immediately.
